// File: rtl/hci_ecc_err_logger.sv
`default_nettype none
// ============================================================================
// Module      : hci_ecc_err_logger
// Description : Counts corrected/uncorrectable ECC errors on granted requests,
//               raises a level interrupt, optionally logs the first bad address
//               (macro HCI_ECC_ERR_ADDR_LOG_EN).
// Revision    : 1.0 - initial release
// ============================================================================
module hci_ecc_err_logger #(
    parameter int N_CHUNK    = 1,
    parameter int AW         = 32,
    parameter int CNT_W      = 16,
    parameter int SINGLE_THR = 8
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               req_i,
    input  logic               gnt_i,
    input  logic [AW-1:0]      add_i,
    input  logic [N_CHUNK-1:0] data_single_err_i,
    input  logic [N_CHUNK-1:0] data_multi_err_i,
    input  logic               meta_single_err_i,
    input  logic               meta_multi_err_i,
    input  logic               clear_i,
    input  logic               irq_ack_i,
    output logic [CNT_W-1:0]   single_cnt_o,
    output logic [CNT_W-1:0]   multi_cnt_o,
    output logic               sat_o,
    output logic               irq_o,
    output logic [AW-1:0]      err_add_o,
    output logic               err_add_valid_o
);

    localparam int               c_inc_w   = $clog2(N_CHUNK + 2);
    localparam logic [CNT_W:0]   c_cnt_max = {1'b0, {CNT_W{1'b1}}};
    localparam logic [CNT_W:0]   c_thr     = (CNT_W + 1)'(SINGLE_THR);

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_PEND = 1'b1
    } irq_state_t;

    logic                w_hs;
    logic [c_inc_w-1:0]  w_inc_s;
    logic [c_inc_w-1:0]  w_inc_m;
    logic [CNT_W:0]      w_sum_s;
    logic [CNT_W:0]      w_sum_m;
    logic [CNT_W-1:0]    w_next_s;
    logic [CNT_W-1:0]    w_next_m;
    logic                w_cross;
    logic                w_trigger;
    logic [CNT_W-1:0]    r_single_cnt;
    logic [CNT_W-1:0]    r_multi_cnt;
    logic                r_sat;
    irq_state_t          r_state;
    irq_state_t          w_state_next;

    assign w_hs = req_i & gnt_i;

    always_comb begin
        w_inc_s = {{(c_inc_w-1){1'b0}}, meta_single_err_i};
        w_inc_m = {{(c_inc_w-1){1'b0}}, meta_multi_err_i};
        for (int i = 0; i < N_CHUNK; i++) begin
            w_inc_s = w_inc_s + c_inc_w'(data_single_err_i[i]);
            w_inc_m = w_inc_m + c_inc_w'(data_multi_err_i[i]);
        end
    end

    // One spare bit keeps the sum from wrapping before the saturation clamp.
    assign w_sum_s  = {1'b0, r_single_cnt} + (CNT_W + 1)'(w_inc_s);
    assign w_sum_m  = {1'b0, r_multi_cnt}  + (CNT_W + 1)'(w_inc_m);
    assign w_next_s = !w_hs ? r_single_cnt :
                      (w_sum_s > c_cnt_max) ? c_cnt_max[CNT_W-1:0] : w_sum_s[CNT_W-1:0];
    assign w_next_m = !w_hs ? r_multi_cnt :
                      (w_sum_m > c_cnt_max) ? c_cnt_max[CNT_W-1:0] : w_sum_m[CNT_W-1:0];

    assign w_cross   = ({1'b0, r_single_cnt} < c_thr) && ({1'b0, w_next_s} >= c_thr);
    assign w_trigger = (w_hs && (w_inc_m != '0)) || w_cross;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_single_cnt <= '0;
            r_multi_cnt  <= '0;
            r_sat        <= 1'b0;
            r_state      <= ST_IDLE;
        end else begin
            if (clear_i) begin
                r_single_cnt <= '0;
                r_multi_cnt  <= '0;
                r_sat        <= 1'b0;
            end else begin
                r_single_cnt <= w_next_s;
                r_multi_cnt  <= w_next_m;
                r_sat        <= r_sat || (w_next_s == c_cnt_max[CNT_W-1:0])
                                      || (w_next_m == c_cnt_max[CNT_W-1:0]);
            end
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE: if (w_trigger)               w_state_next = ST_PEND;
            ST_PEND: if (irq_ack_i && !w_trigger) w_state_next = ST_IDLE;
            default:                              w_state_next = ST_IDLE;
        endcase
        if (clear_i) w_state_next = ST_IDLE;
    end

    assign single_cnt_o = r_single_cnt;
    assign multi_cnt_o  = r_multi_cnt;
    assign sat_o        = r_sat;
    assign irq_o        = (r_state == ST_PEND);

`ifdef HCI_ECC_ERR_ADDR_LOG_EN
    logic [AW-1:0] r_err_add;
    logic          r_err_add_valid;

    // Only the first uncorrectable error is kept until software clears it.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_err_add       <= '0;
            r_err_add_valid <= 1'b0;
        end else if (clear_i) begin
            r_err_add       <= '0;
            r_err_add_valid <= 1'b0;
        end else if (w_hs && (w_inc_m != '0) && !r_err_add_valid) begin
            r_err_add       <= add_i;
            r_err_add_valid <= 1'b1;
        end
    end

    assign err_add_o       = r_err_add;
    assign err_add_valid_o = r_err_add_valid;
`else
    logic w_unused_add;
    assign w_unused_add    = ^add_i;
    assign err_add_o       = '0;
    assign err_add_valid_o = 1'b0;
`endif

endmodule
`default_nettype wire
